// File: rtl/sc_regcounter_ctrl_pkg.sv
// Shared definitions for the counter sequencing controller: state codes
// and the active levels of the low-true strobes and requests.
package sc_regcounter_ctrl_pkg;

  localparam int STATE_WIDTH = 2;

  typedef logic [STATE_WIDTH-1:0] state_t;

  localparam state_t ST_IDLE  = 2'b00;
  localparam state_t ST_CLEAR = 2'b01;
  localparam state_t ST_RUN   = 2'b10;
  localparam state_t ST_HOLD  = 2'b11;

  // Levels of the _InLow / _OutLow signals.
  localparam logic LOW_ACTIVE   = 1'b0;
  localparam logic LOW_INACTIVE = 1'b1;

endpackage

// File: rtl/sc_regcounter_ctrl_prescaler_tick.sv
// Modulo-PRESCALE cycle counter that marks the increment strobe cycle.
// Holds its value while disabled and returns to zero on a sync clear.
module sc_prescaler_tick #(
  parameter int PRESCALE = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic strobe_o
);

  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count: clear wins, otherwise advance and wrap when enabled.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign strobe_o = (cnt_q == LAST);

endmodule

// File: rtl/sc_regcounter_ctrl.sv
// Sequencing controller for the 8-bit up-counter register: clears it,
// paces its increment strobes, wraps it at a terminal value and counts
// wraps with saturation.
module sc_regcounter_ctrl
  import sc_regcounter_ctrl_pkg::*;
#(
  parameter int DATAWIDTH = 8,
  parameter int PRESCALE  = 4,
  parameter int WRAPWIDTH = 4
) (
  input  logic                 SC_RegCOUNTERCTRL_CLOCK_50,
  input  logic                 SC_RegCOUNTERCTRL_RESET_InLow,
  input  logic                 SC_RegCOUNTERCTRL_start_InLow,
  input  logic                 SC_RegCOUNTERCTRL_pause_InLow,
  input  logic [DATAWIDTH-1:0] SC_RegCOUNTERCTRL_limit_InBUS,
  input  logic [DATAWIDTH-1:0] SC_RegCOUNTERCTRL_count_InBUS,
  output logic                 SC_RegCOUNTERCTRL_load_OutLow,
  output logic                 SC_RegCOUNTERCTRL_clear_OutHigh,
  output logic                 SC_RegCOUNTERCTRL_tick_OutHigh,
  output logic [1:0]           SC_RegCOUNTERCTRL_state_OutBUS,
  output logic [WRAPWIDTH-1:0] SC_RegCOUNTERCTRL_wraps_OutBUS
);

  logic clk;
  logic rst_n;
  assign clk   = SC_RegCOUNTERCTRL_CLOCK_50;
  assign rst_n = SC_RegCOUNTERCTRL_RESET_InLow;

  state_t               state_q, state_d;
  logic [DATAWIDTH-1:0] limit_q, limit_d;
  logic [WRAPWIDTH-1:0] wraps_q, wraps_d;

  logic start_req;
  logic pause_req;
  logic start_acc;
  logic presc_last;
  logic presc_en;
  logic presc_clr;
  logic strobe_cycle;
  logic at_limit;
  logic wrap_cycle;
  logic inc_cycle;

  // A start with a zero terminal value is meaningless and is dropped;
  // CLEAR always proceeds to RUN so start is not honoured there.
  assign start_req = (SC_RegCOUNTERCTRL_start_InLow == LOW_ACTIVE);
  assign pause_req = (SC_RegCOUNTERCTRL_pause_InLow == LOW_ACTIVE);
  assign start_acc = start_req && (SC_RegCOUNTERCTRL_limit_InBUS != '0) &&
                     (state_q != ST_CLEAR);

  // Prescaler advances in every RUN cycle except one that restarts;
  // it is frozen in HOLD and zeroed while in CLEAR.
  assign presc_en  = (state_q == ST_RUN) && !start_acc;
  assign presc_clr = (state_q == ST_CLEAR);

  sc_prescaler_tick #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (presc_en),
    .clr      (presc_clr),
    .strobe_o (presc_last)
  );

  // Restart and pause both take precedence over a strobe in the same cycle.
  // The >= test also catches a readback that has overshot or is corrupt.
  assign strobe_cycle = (state_q == ST_RUN) && presc_last && !start_acc && !pause_req;
  assign at_limit     = (SC_RegCOUNTERCTRL_count_InBUS >= limit_q);
  assign wrap_cycle   = strobe_cycle && at_limit;
  assign inc_cycle    = strobe_cycle && !at_limit;

  // Next-state, terminal latch and saturating wrap count.
  always_comb begin
    state_d = state_q;
    limit_d = limit_q;
    wraps_d = wraps_q;
    case (state_q)
      ST_IDLE: begin
        if (start_acc) begin
          state_d = ST_CLEAR;
          limit_d = SC_RegCOUNTERCTRL_limit_InBUS;
        end
      end
      ST_CLEAR: begin
        state_d = ST_RUN;
        wraps_d = '0;
      end
      ST_RUN: begin
        if (start_acc) begin
          state_d = ST_CLEAR;
          limit_d = SC_RegCOUNTERCTRL_limit_InBUS;
        end else if (pause_req) begin
          state_d = ST_HOLD;
        end else if (wrap_cycle && (wraps_q != '1)) begin
          wraps_d = wraps_q + WRAPWIDTH'(1);
        end
      end
      ST_HOLD: begin
        if (start_acc) begin
          state_d = ST_CLEAR;
          limit_d = SC_RegCOUNTERCTRL_limit_InBUS;
        end else if (!pause_req) begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Controller registers; reset drops straight back to IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      limit_q <= '0;
      wraps_q <= '0;
    end else begin
      state_q <= state_d;
      limit_q <= limit_d;
      wraps_q <= wraps_d;
    end
  end

  // Strobe decode; load and clear are exclusive by construction since
  // inc_cycle and wrap_cycle cannot both be true and neither occurs in CLEAR.
  always_comb begin
    SC_RegCOUNTERCTRL_load_OutLow   = inc_cycle ? LOW_ACTIVE : LOW_INACTIVE;
    SC_RegCOUNTERCTRL_clear_OutHigh = (state_q == ST_CLEAR) || wrap_cycle;
    SC_RegCOUNTERCTRL_tick_OutHigh  = wrap_cycle;
    SC_RegCOUNTERCTRL_state_OutBUS  = state_q;
    SC_RegCOUNTERCTRL_wraps_OutBUS  = wraps_q;
  end

endmodule

// File: tb/tb_sc_regcounter_ctrl.sv
// Directed bench for sc_regcounter_ctrl with a behavioural model of the
// counter register and a queue of expected tick cycles.
module tb_sc_regcounter_ctrl;

   localparam int DW = 8;
   localparam int PS = 4;
   localparam int WW = 4;

   logic          clock = 1'b0;
   logic          resetN = 1'b0;
   logic          startN = 1'b1;
   logic          pauseN = 1'b1;
   logic [DW-1:0] limitIn = '0;
   logic [DW-1:0] countIn;
   logic          loadN;
   logic          clearOut;
   logic          tickOut;
   logic [1:0]    stateOut;
   logic [WW-1:0] wrapsOut;

   logic [DW-1:0] modelCount;
   logic          forceHigh = 1'b0;

   int cyc = 0;
   int expQ[$];
   int testsRun = 0;
   int testsFailed = 0;

   int k0, p, r0, r, s, z, k;

   sc_regcounter_ctrl #(
      .DATAWIDTH (DW),
      .PRESCALE  (PS),
      .WRAPWIDTH (WW)
   ) dut (
      .SC_RegCOUNTERCTRL_CLOCK_50      (clock),
      .SC_RegCOUNTERCTRL_RESET_InLow   (resetN),
      .SC_RegCOUNTERCTRL_start_InLow   (startN),
      .SC_RegCOUNTERCTRL_pause_InLow   (pauseN),
      .SC_RegCOUNTERCTRL_limit_InBUS   (limitIn),
      .SC_RegCOUNTERCTRL_count_InBUS   (countIn),
      .SC_RegCOUNTERCTRL_load_OutLow   (loadN),
      .SC_RegCOUNTERCTRL_clear_OutHigh (clearOut),
      .SC_RegCOUNTERCTRL_tick_OutHigh  (tickOut),
      .SC_RegCOUNTERCTRL_state_OutBUS  (stateOut),
      .SC_RegCOUNTERCTRL_wraps_OutBUS  (wrapsOut)
   );

   // 50 MHz clock.
   always #10 clock = ~clock;

   // Cycle index, bumped on every rising edge.
   always @(posedge clock) cyc++;

   // Behavioural counter register driven by the controller's strobes.
   always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) begin
         modelCount <= '0;
      end else if (clearOut) begin
         modelCount <= '0;
      end else if (!loadN) begin
         modelCount <= modelCount + 8'd1;
      end
   end

   assign countIn = forceHigh ? 8'd7 : modelCount;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      testsRun++;
      assert (obs === exp) else begin
         testsFailed++;
         $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(input logic s_n, input logic p_n, input logic [DW-1:0] lim);
      startN  = s_n;
      pauseN  = p_n;
      limitIn = lim;
   endtask

   task automatic goCycle(input int target);
      while (cyc < target) begin
         @(posedge clock);
         #1;
      end
   endtask

   // Ticks are matched against the queued cycle numbers; strobes are
   // also checked for exclusivity and for appearing only in RUN/CLEAR.
   always @(negedge clock) begin
      if (resetN) begin
         if (tickOut) begin
            if (expQ.size() == 0) checkOutput("unexpected_tick", 32'(cyc), 32'(0));
            else checkOutput("tick_cycle", 32'(cyc), 32'(expQ.pop_front()));
         end
         if (!loadN || clearOut) begin
            checkOutput("strobe_exclusive", 32'(!loadN && clearOut), 32'(0));
            checkOutput("strobe_state", 32'(stateOut == 2'b10 || stateOut == 2'b01), 32'(1));
         end
      end
   end

   // Directed sequence.
   initial begin
      applyStimulus(1'b1, 1'b1, 8'd0);
      repeat (3) @(negedge clock);
      checkOutput("rst_state", 32'(stateOut), 32'(0));
      checkOutput("rst_load", 32'(loadN), 32'(1));
      checkOutput("rst_clear", 32'(clearOut), 32'(0));
      checkOutput("rst_tick", 32'(tickOut), 32'(0));
      checkOutput("rst_wraps", 32'(wrapsOut), 32'(0));
      @(posedge clock);
      #1;
      resetN = 1'b1;
      goCycle(cyc + 2);
      @(negedge clock);
      checkOutput("idle_after_rst", 32'(stateOut), 32'(0));

      // Start with zero terminal is ignored.
      k = cyc + 1;
      goCycle(k);
      applyStimulus(1'b0, 1'b1, 8'd0);
      @(negedge clock);
      checkOutput("lim0_clear_now", 32'(clearOut), 32'(0));
      goCycle(k + 1);
      applyStimulus(1'b1, 1'b1, 8'd0);
      @(negedge clock);
      checkOutput("lim0_state", 32'(stateOut), 32'(0));
      checkOutput("lim0_clear", 32'(clearOut), 32'(0));

      // Normal run with limit 3: 16-cycle wrap period.
      k0 = cyc + 1;
      goCycle(k0);
      applyStimulus(1'b0, 1'b1, 8'd3);
      expQ.push_back(k0 + 17);
      expQ.push_back(k0 + 33);
      expQ.push_back(k0 + 49);
      goCycle(k0 + 1);
      applyStimulus(1'b1, 1'b1, 8'd3);
      @(negedge clock);
      checkOutput("clr_state", 32'(stateOut), 32'(1));
      checkOutput("clr_clear", 32'(clearOut), 32'(1));
      checkOutput("clr_load", 32'(loadN), 32'(1));
      goCycle(k0 + 2);
      @(negedge clock);
      checkOutput("run_state", 32'(stateOut), 32'(2));
      checkOutput("clear_one_cycle", 32'(clearOut), 32'(0));
      goCycle(k0 + 4);
      @(negedge clock);
      checkOutput("pre_strobe_load", 32'(loadN), 32'(1));
      goCycle(k0 + 5);
      @(negedge clock);
      checkOutput("strobe1_load", 32'(loadN), 32'(0));
      goCycle(k0 + 9);
      @(negedge clock);
      checkOutput("strobe2_count", 32'(countIn), 32'(1));
      checkOutput("strobe2_load", 32'(loadN), 32'(0));
      goCycle(k0 + 17);
      @(negedge clock);
      checkOutput("wrap_clear", 32'(clearOut), 32'(1));
      checkOutput("wrap_load", 32'(loadN), 32'(1));
      goCycle(k0 + 18);
      @(negedge clock);
      checkOutput("wraps_1", 32'(wrapsOut), 32'(1));

      // Pause 10 cycles: next tick slips by exactly 10.
      p = k0 + 51;
      goCycle(p);
      applyStimulus(1'b1, 1'b0, 8'd3);
      expQ.push_back(k0 + 75);
      goCycle(p + 1);
      @(negedge clock);
      checkOutput("hold_state", 32'(stateOut), 32'(3));
      checkOutput("hold_wraps", 32'(wrapsOut), 32'(3));
      goCycle(p + 5);
      @(negedge clock);
      checkOutput("hold_load", 32'(loadN), 32'(1));
      goCycle(p + 10);
      applyStimulus(1'b1, 1'b1, 8'd3);
      goCycle(p + 11);
      @(negedge clock);
      checkOutput("resume_state", 32'(stateOut), 32'(2));

      // Restart with zero terminal during RUN is ignored.
      r0 = k0 + 77;
      goCycle(r0);
      applyStimulus(1'b0, 1'b1, 8'd0);
      goCycle(r0 + 1);
      applyStimulus(1'b1, 1'b1, 8'd0);
      @(negedge clock);
      checkOutput("rst0_state", 32'(stateOut), 32'(2));
      checkOutput("rst0_clear", 32'(clearOut), 32'(0));

      // Restart with limit 5 on a strobe cycle: 24-cycle period.
      r = k0 + 79;
      goCycle(r);
      applyStimulus(1'b0, 1'b1, 8'd5);
      expQ.push_back(r + 25);
      expQ.push_back(r + 49);
      goCycle(r + 1);
      applyStimulus(1'b1, 1'b1, 8'd9);
      @(negedge clock);
      checkOutput("restart_state", 32'(stateOut), 32'(1));
      checkOutput("restart_clear", 32'(clearOut), 32'(1));
      goCycle(r + 2);
      @(negedge clock);
      checkOutput("restart_wraps", 32'(wrapsOut), 32'(0));
      goCycle(r + 26);
      @(negedge clock);
      checkOutput("lim5_wraps", 32'(wrapsOut), 32'(1));

      // Limit 1: 8-cycle period, wrap count saturates.
      s = r + 50;
      goCycle(s);
      applyStimulus(1'b0, 1'b1, 8'd1);
      for (int j = 0; j < 17; j++) expQ.push_back(s + 9 + 8 * j);
      goCycle(s + 1);
      applyStimulus(1'b1, 1'b1, 8'd1);
      goCycle(s + 2);
      @(negedge clock);
      checkOutput("sat_start_wraps", 32'(wrapsOut), 32'(0));
      goCycle(s + 122);
      @(negedge clock);
      checkOutput("sat_reach", 32'(wrapsOut), 32'(15));
      goCycle(s + 138);
      @(negedge clock);
      checkOutput("sat_hold", 32'(wrapsOut), 32'(15));

      // Overshot readback forces a wrap on the next strobe.
      goCycle(s + 139);
      forceHigh = 1'b1;
      expQ.push_back(s + 141);
      goCycle(s + 141);
      @(negedge clock);
      checkOutput("over_clear", 32'(clearOut), 32'(1));
      checkOutput("over_load", 32'(loadN), 32'(1));
      goCycle(s + 142);
      forceHigh = 1'b0;

      // Asynchronous reset in the middle of a strobe cycle.
      goCycle(s + 145);
      checkOutput("pre_reset_load", 32'(loadN), 32'(0));
      #2;
      resetN = 1'b0;
      #1;
      checkOutput("async_state", 32'(stateOut), 32'(0));
      checkOutput("async_load", 32'(loadN), 32'(1));
      checkOutput("async_clear", 32'(clearOut), 32'(0));
      checkOutput("async_wraps", 32'(wrapsOut), 32'(0));
      checkOutput("queue_drained", 32'(expQ.size()), 32'(0));
      @(posedge clock);
      #1;
      resetN = 1'b1;

      // Start and pause together from IDLE: CLEAR, RUN, then HOLD.
      z = cyc + 1;
      goCycle(z);
      applyStimulus(1'b0, 1'b0, 8'd2);
      goCycle(z + 1);
      applyStimulus(1'b1, 1'b0, 8'd2);
      @(negedge clock);
      checkOutput("sp_clear", 32'(stateOut), 32'(1));
      goCycle(z + 2);
      @(negedge clock);
      checkOutput("sp_run", 32'(stateOut), 32'(2));
      goCycle(z + 3);
      @(negedge clock);
      checkOutput("sp_hold", 32'(stateOut), 32'(3));
      checkOutput("sp_hold_load", 32'(loadN), 32'(1));
      goCycle(z + 4);
      applyStimulus(1'b1, 1'b1, 8'd2);
      goCycle(z + 5);
      @(negedge clock);
      checkOutput("sp_resume", 32'(stateOut), 32'(2));

      checkOutput("pending_ticks", 32'(expQ.size()), 32'(0));
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
